// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the RAM instruction port.
// Define ICACHE_EN to build the tag/data arrays; otherwise every fetch goes to RAM.
module icache #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        fetch_en_in,
   input  logic [31:0] fetch_addr_in,
   input  logic        flush_in,
   output logic        fetch_rdy_out,
   output logic [31:0] fetch_inst_out,
   output logic        mem_en_out,
   output logic [31:0] mem_addr_out,
   input  logic        mem_rdy_in,
   input  logic [31:0] mem_inst_in
);

   typedef enum logic [1:0] {IDLE, MISS, DROP} state_e;

   state_e      state_q, state_d;
   logic        rdy_q, rdy_d;
   logic [31:0] inst_q, inst_d;
   logic        en_q, en_d;
   logic [31:0] addr_q, addr_d;
   logic        fill;
   logic        hit;
   logic [31:0] hit_data;
   logic        unused_addr;

   assign unused_addr = ^fetch_addr_in[1:0];

`ifdef ICACHE_EN
   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = 30 - INDEX_WIDTH;

   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q [LINES];
   logic [31:0]            data_q [LINES];
   logic [INDEX_WIDTH-1:0] req_idx;
   logic [INDEX_WIDTH-1:0] fill_idx;

   assign req_idx  = fetch_addr_in[INDEX_WIDTH+1:2];
   assign fill_idx = addr_q[INDEX_WIDTH+1:2];
   assign hit      = valid_q[req_idx] &&
                     (tag_q[req_idx] == fetch_addr_in[31:INDEX_WIDTH+2]);
   assign hit_data = data_q[req_idx];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (rdy_in && fill) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag/data need no reset: the valid bits gate every use.
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && fill) begin
         tag_q[fill_idx]  <= addr_q[31:INDEX_WIDTH+2];
         data_q[fill_idx] <= mem_inst_in;
      end
   end
`else
   logic unused_fill;

   assign hit         = 1'b0;
   assign hit_data    = '0;
   assign unused_fill = fill;
`endif

   always_comb begin
      state_d = state_q;
      rdy_d   = 1'b0;
      inst_d  = inst_q;
      en_d    = en_q;
      addr_d  = addr_q;
      fill    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!flush_in && fetch_en_in) begin
               if (hit) begin
                  rdy_d  = 1'b1;
                  inst_d = hit_data;
               end else begin
                  addr_d  = {fetch_addr_in[31:2], 2'b00};
                  en_d    = 1'b1;
                  state_d = MISS;
               end
            end
         end
         MISS: begin
            if (mem_rdy_in) begin
               fill    = 1'b1;
               en_d    = 1'b0;
               state_d = IDLE;
               if (!flush_in) begin
                  rdy_d  = 1'b1;
                  inst_d = mem_inst_in;
               end
            end else if (flush_in) begin
               state_d = DROP;
            end
         end
         DROP: begin
            // Let the RAM read finish so the controller is never left mid-transfer.
            if (mem_rdy_in) begin
               fill    = 1'b1;
               en_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         inst_q  <= '0;
         en_q    <= 1'b0;
         addr_q  <= '0;
      end else if (rdy_in) begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         inst_q  <= inst_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
      end
   end

   assign fetch_rdy_out  = rdy_q;
   assign fetch_inst_out = inst_q;
   assign mem_en_out     = en_q;
   assign mem_addr_out   = addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache; the bench plays the RAM controller.
// Hit expectations follow ICACHE_EN; without it every fetch is a RAM read.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        fetch_en;
   logic [31:0] fetch_addr;
   logic        flush;
   logic        fetch_rdy;
   logic [31:0] fetch_inst;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic        mem_rdy;
   logic [31:0] mem_inst;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   icache #(.INDEX_WIDTH(6)) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .rdy_in        (rdy),
      .fetch_en_in   (fetch_en),
      .fetch_addr_in (fetch_addr),
      .flush_in      (flush),
      .fetch_rdy_out (fetch_rdy),
      .fetch_inst_out(fetch_inst),
      .mem_en_out    (mem_en),
      .mem_addr_out  (mem_addr),
      .mem_rdy_in    (mem_rdy),
      .mem_inst_in   (mem_inst)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [31:0] a);
      fetch_en   = 1'b1;
      fetch_addr = a;
      tick();
      fetch_en   = 1'b0;
   endtask

   // Called one edge after the request; RAM answers 6 cycles after enable.
   task automatic do_miss(input string tag, input logic [31:0] a,
                          input logic [31:0] d);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      check({tag, ".en"}, 32'(mem_en), 32'd1);
      check({tag, ".addr"}, mem_addr, wa);
      for (int i = 0; i < 6; i++) begin
         tick();
         check({tag, ".hold"}, mem_addr, wa);
      end
      mem_rdy  = 1'b1;
      mem_inst = d;
      tick();
      mem_rdy  = 1'b0;
      check({tag, ".rdy"}, 32'(fetch_rdy), 32'd1);
      check({tag, ".inst"}, fetch_inst, d);
      check({tag, ".en_off"}, 32'(mem_en), 32'd0);
      tick();
      check({tag, ".pulse"}, 32'(fetch_rdy), 32'd0);
   endtask

   task automatic read_hit(input string tag, input logic [31:0] a,
                           input logic [31:0] d);
      request(a);
`ifdef ICACHE_EN
      check({tag, ".rdy"}, 32'(fetch_rdy), 32'd1);
      check({tag, ".inst"}, fetch_inst, d);
      check({tag, ".en"}, 32'(mem_en), 32'd0);
      tick();
      check({tag, ".pulse"}, 32'(fetch_rdy), 32'd0);
`else
      do_miss(tag, a, d);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      rdy        = 1'b1;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      flush      = 1'b0;
      mem_rdy    = 1'b0;
      mem_inst   = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst.rdy", 32'(fetch_rdy), 32'd0);
      check("rst.inst", fetch_inst, 32'd0);
      check("rst.en", 32'(mem_en), 32'd0);
      check("rst.addr", mem_addr, 32'd0);

      request(32'h4);
      do_miss("cold", 32'h4, 32'h0010_0093);
      read_hit("rehit", 32'h4, 32'h0010_0093);

      fetch_en   = 1'b1;
      fetch_addr = 32'h4;
      flush      = 1'b1;
      tick();
      fetch_en = 1'b0;
      flush    = 1'b0;
      check("idleflush.rdy", 32'(fetch_rdy), 32'd0);
      check("idleflush.en", 32'(mem_en), 32'd0);

      request(32'h104);
      do_miss("conflict", 32'h104, 32'hDEAD_BEEF);
      request(32'h4);
      do_miss("evicted", 32'h4, 32'h0010_0093);
      read_hit("rehit2", 32'h4, 32'h0010_0093);

      request(32'h8);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("drop.en", 32'(mem_en), 32'd1);
      check("drop.addr", mem_addr, 32'h8);
      check("drop.rdy0", 32'(fetch_rdy), 32'd0);
      fetch_en   = 1'b1;
      fetch_addr = 32'h40;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop.hold", mem_addr, 32'h8);
      end
      fetch_en = 1'b0;
      mem_rdy  = 1'b1;
      mem_inst = 32'h1111_1111;
      tick();
      mem_rdy = 1'b0;
      check("drop.rdy1", 32'(fetch_rdy), 32'd0);
      check("drop.en_off", 32'(mem_en), 32'd0);
      tick();
      check("drop.rdy2", 32'(fetch_rdy), 32'd0);
      read_hit("dropfill", 32'h8, 32'h1111_1111);

      request(32'hC);
      check("sameflush.en", 32'(mem_en), 32'd1);
      tick();
      tick();
      mem_rdy  = 1'b1;
      mem_inst = 32'h2222_2222;
      flush    = 1'b1;
      tick();
      mem_rdy = 1'b0;
      flush   = 1'b0;
      check("sameflush.rdy", 32'(fetch_rdy), 32'd0);
      check("sameflush.en_off", 32'(mem_en), 32'd0);
      read_hit("sameflushfill", 32'hC, 32'h2222_2222);

      request(32'hFFFF_FFFF);
      do_miss("wrap", 32'hFFFF_FFFC, 32'h1234_5678);
      read_hit("wraphit", 32'hFFFF_FFFD, 32'h1234_5678);

`ifdef ICACHE_EN
      fetch_en   = 1'b1;
      fetch_addr = 32'h4;
      tick();
      check("b2b.rdy1", 32'(fetch_rdy), 32'd1);
      check("b2b.inst1", fetch_inst, 32'h0010_0093);
      fetch_addr = 32'hC;
      tick();
      fetch_en = 1'b0;
      check("b2b.rdy2", 32'(fetch_rdy), 32'd1);
      check("b2b.inst2", fetch_inst, 32'h2222_2222);
      tick();
      check("b2b.end", 32'(fetch_rdy), 32'd0);
`endif

      request(32'h10);
      tick();
      tick();
      rdy      = 1'b0;
      mem_rdy  = 1'b1;
      mem_inst = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall.en", 32'(mem_en), 32'd1);
         check("stall.rdy", 32'(fetch_rdy), 32'd0);
      end
      rdy     = 1'b1;
      mem_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall.addr", mem_addr, 32'h10);
      end
      mem_rdy  = 1'b1;
      mem_inst = 32'hA0A0_A0A0;
      tick();
      mem_rdy = 1'b0;
      check("stall.done", 32'(fetch_rdy), 32'd1);
      check("stall.inst", fetch_inst, 32'hA0A0_A0A0);
      rdy = 1'b0;
      tick();
      check("stall.keep", 32'(fetch_rdy), 32'd1);
      rdy = 1'b1;
      tick();
      check("stall.release", 32'(fetch_rdy), 32'd0);

      request(32'h14);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.rdy", 32'(fetch_rdy), 32'd0);
      check("midrst.inst", fetch_inst, 32'd0);
      check("midrst.en", 32'(mem_en), 32'd0);
      check("midrst.addr", mem_addr, 32'd0);
      request(32'h4);
      do_miss("postrst", 32'h4, 32'h0010_0093);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
